// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for a multiplexed 8-digit seven-segment bus. It waits for each
// digit strobe to settle, decodes the segment pattern once per dwell, and offers whole frames.
module seg_scan_decoder #(
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  scan,
    input  logic [7:0]  segs_in,
    output logic [31:0] frame_data,
    output logic [7:0]  frame_dp,
    output logic [7:0]  frame_err,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic        overrun,
    output logic        scan_fault
);

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] CNT_MAX     = 16'hFFFF;

    typedef enum logic [0:0] {
        S_SETTLE = 1'b0,
        S_HOLD   = 1'b1
    } state_t;

    // Handshake: a frame is offered while frame_valid=1 and is consumed on every clk
    // edge that sees frame_valid && frame_ready; until then frame_* does not change.

    // Returns {err, nibble}; dp is ignored by forcing bit7 high before the compare.
    function automatic logic [4:0] decode_seg(input logic [6:0] pat);
        logic [4:0] res;
        case ({1'b1, pat})
            8'hC0:   res = 5'h00;
            8'hF9:   res = 5'h01;
            8'hA4:   res = 5'h02;
            8'hB0:   res = 5'h03;
            8'h99:   res = 5'h04;
            8'h92:   res = 5'h05;
            8'h82:   res = 5'h06;
            8'hF8:   res = 5'h07;
            8'h80:   res = 5'h08;
            8'h98:   res = 5'h09;
            8'h88:   res = 5'h0A;
            8'h83:   res = 5'h0B;
            8'hC6:   res = 5'h0C;
            8'hA1:   res = 5'h0D;
            8'h86:   res = 5'h0E;
            8'h8E:   res = 5'h0F;
            default: res = 5'h10;
        endcase
        return res;
    endfunction

    logic [7:0]  scan_q;
    logic [7:0]  segs_q;
    logic [7:0]  scan_prev;
    logic [7:0]  sel;
    logic        scan_valid;
    logic        scan_changed;
    logic [2:0]  digit_idx;
    logic [4:0]  dec;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        sample;

    logic [7:0]  mask_q;
    logic [31:0] stage_data;
    logic [7:0]  stage_dp;
    logic [7:0]  stage_err;
    logic        frame_done;
    logic        load_frame;
    logic        fault_armed;

    // The input pipeline just follows the pins, so after reset it already holds live values.
    always_ff @(posedge clk) begin
        scan_q    <= scan;
        segs_q    <= segs_in;
        scan_prev <= scan_q;
    end

    always_comb begin
        sel          = ~scan_q;
        scan_valid   = (sel != 8'h00) && ((sel & (sel - 8'h01)) == 8'h00);
        scan_changed = (scan_q != scan_prev);
        digit_idx    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (sel[i]) begin
                digit_idx = 3'(i);
            end
        end
        dec = decode_seg(segs_q[6:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_SETTLE;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sample  = 1'b0;
        case (state_q)
            S_SETTLE: begin
                if (scan_changed || !scan_valid) begin
                    cnt_d = 16'd0;
                end else if (cnt_q == SETTLE_LAST) begin
                    sample  = 1'b1;
                    state_d = S_HOLD;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_HOLD: begin
                if (scan_changed) begin
                    state_d = S_SETTLE;
                    cnt_d   = 16'd0;
                end
            end
            default: begin
                state_d = S_SETTLE;
                cnt_d   = 16'd0;
            end
        endcase
    end

    // A sample can never coincide with frame_done: the cycle after a sample is spent in S_HOLD.
    assign frame_done = (mask_q == 8'hFF);
    assign load_frame = frame_done && (!frame_valid || frame_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q     <= 8'h00;
            stage_data <= 32'h0;
            stage_dp   <= 8'h00;
            stage_err  <= 8'h00;
        end else if (frame_done) begin
            mask_q <= 8'h00;
        end else if (sample) begin
            mask_q[digit_idx]                    <= 1'b1;
            stage_data[{digit_idx, 2'b00} +: 4] <= dec[3:0];
            stage_err[digit_idx]                 <= dec[4];
            stage_dp[digit_idx]                  <= ~segs_q[7];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_data  <= 32'h0;
            frame_dp    <= 8'h00;
            frame_err   <= 8'h00;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
            scan_fault  <= 1'b0;
            fault_armed <= 1'b1;
        end else begin
            overrun     <= frame_done && frame_valid && !frame_ready;
            scan_fault  <= !scan_valid && fault_armed;
            fault_armed <= scan_valid;
            if (load_frame) begin
                frame_data  <= stage_data;
                frame_dp    <= stage_dp;
                frame_err   <= stage_err;
                frame_valid <= 1'b1;
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed and random digit dwells checked against a
// frame-level model of settling, decoding, frame hand-off, overrun and scan faults.
module tb_seg_scan_decoder;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  scan;
    logic [7:0]  segs_in;
    logic [31:0] frame_data;
    logic [7:0]  frame_dp;
    logic [7:0]  frame_err;
    logic        frame_valid;
    logic        frame_ready;
    logic        overrun;
    logic        scan_fault;

    seg_scan_decoder #(.SETTLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .scan        (scan),
        .segs_in     (segs_in),
        .frame_data  (frame_data),
        .frame_dp    (frame_dp),
        .frame_err   (frame_err),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .overrun     (overrun),
        .scan_fault  (scan_fault)
    );

    always #5 clk = ~clk;

    // Patterns for hex 0..F on segments g..a, active-low.
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int n_checks = 0;
    int n_fail   = 0;
    int ovr_cnt  = 0;
    int flt_cnt  = 0;
    int exp_ovr  = 0;
    int exp_flt  = 0;

    logic [3:0]  m_nib [8];
    logic [7:0]  m_dp;
    logic [7:0]  m_err;
    logic [7:0]  m_mask;
    bit          m_fv;
    bit          m_armed;
    logic [47:0] exp_q [$];

    always @(negedge clk) begin
        if (overrun) ovr_cnt++;
        if (scan_fault) flt_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int low_index(input logic [7:0] s);
        int idx = -1;
        int n = 0;
        for (int i = 0; i < 8; i++) begin
            if (!s[i]) begin
                idx = i;
                n++;
            end
        end
        return (n == 1) ? idx : -1;
    endfunction

    task automatic model_reset();
        m_mask  = 8'h00;
        m_fv    = 1'b0;
        m_armed = 1'b1;
        exp_q.delete();
    endtask

    // One dwell of a scan value: faults on entry to an invalid value, a sample when the
    // dwell is long enough, and a frame hand-off when all eight digits are present.
    task automatic model_dwell(input logic [7:0] sv, input logic [7:0] gv, input int len,
                               input bit rdy);
        int          idx;
        logic [3:0]  nib;
        bit          err;
        logic [31:0] dat;
        idx = low_index(sv);
        if (idx < 0) begin
            if (m_armed) exp_flt++;
            m_armed = 1'b0;
            return;
        end
        m_armed = 1'b1;
        if (len < S + 1) return;
        nib = 4'h0;
        err = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (seg_tab[k] == gv[6:0]) begin
                nib = 4'(k);
                err = 1'b0;
            end
        end
        m_nib[idx]  = nib;
        m_err[idx]  = err;
        m_dp[idx]   = ~gv[7];
        m_mask[idx] = 1'b1;
        if (m_mask == 8'hFF) begin
            m_mask = 8'h00;
            for (int i = 0; i < 8; i++) dat[4*i +: 4] = m_nib[i];
            if (!m_fv || rdy) begin
                if (m_fv) void'(exp_q.pop_front());
                exp_q.push_back({m_err, m_dp, dat});
                m_fv = 1'b1;
            end else begin
                exp_ovr++;
            end
        end
    endtask

    // rdy_tick > 0 raises frame_ready for exactly one clk edge at that point of the dwell.
    task automatic dwell(input logic [7:0] sv, input logic [7:0] gv, input int len,
                         input int rdy_tick);
        scan    = sv;
        segs_in = gv;
        for (int t = 1; t <= len; t++) begin
            tick();
            if (rdy_tick > 0 && t == rdy_tick) frame_ready = 1'b1;
            else if (rdy_tick > 0 && t == rdy_tick + 1) frame_ready = 1'b0;
        end
        model_dwell(sv, gv, len, rdy_tick > 0);
    endtask

    task automatic seq(input logic [63:0] pats, input int first, input int last, input int len);
        for (int d = first; d <= last; d++) dwell(~(8'h01 << d), pats[8*d +: 8], len, 0);
    endtask

    task automatic rand_frame(input int rdy_last);
        int         dig;
        int         len;
        bit         dpv;
        logic [7:0] g;
        for (int d = 0; d < 8; d++) begin
            dig = $urandom_range(0, 15);
            dpv = 1'($urandom_range(0, 1));
            g   = {~dpv, seg_tab[dig]};
            if ($urandom_range(0, 7) == 0) g = 8'($urandom);
            len = (d == 7) ? $urandom_range(S + 4, S + 8) : $urandom_range(S + 1, S + 8);
            dwell(~(8'h01 << d), g, len, (d == 7) ? rdy_last : 0);
        end
    endtask

    task automatic check_frame(input string tag);
        logic [47:0] frm;
        check({tag, " valid"}, 32'(frame_valid), 32'(m_fv));
        if (m_fv && exp_q.size() > 0) begin
            frm = exp_q[0];
            check({tag, " data"}, frame_data, frm[31:0]);
            check({tag, " dp"}, 32'(frame_dp), 32'(frm[39:32]));
            check({tag, " err"}, 32'(frame_err), 32'(frm[47:40]));
        end
    endtask

    task automatic accept(input string tag);
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        if (m_fv) void'(exp_q.pop_front());
        m_fv = 1'b0;
        check({tag, " accept"}, 32'(frame_valid), 32'(0));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " valid"}, 32'(frame_valid), 32'(0));
        check({tag, " data"}, frame_data, 32'h0);
        check({tag, " dp"}, 32'(frame_dp), 32'(0));
        check({tag, " err"}, 32'(frame_err), 32'(0));
        check({tag, " overrun"}, 32'(overrun), 32'(0));
        check({tag, " fault"}, 32'(scan_fault), 32'(0));
    endtask

    initial begin
        rst         = 1'b1;
        scan        = 8'hFF;
        segs_in     = 8'hFF;
        frame_ready = 1'b0;
        repeat (3) tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        model_reset();
        dwell(8'hFF, 8'hFF, 6, 0);
        check("fault after reset", 32'(flt_cnt), 32'(exp_flt));

        // Right digits 0,0,0,0 and left digits b,0,A,0.
        seq(64'hC0_88_C0_83_C0_C0_C0_C0, 0, 7, 10);
        check_frame("frame1");
        check("frame1 literal", frame_data, 32'h0A0B0000);

        // No consumer across a second frame: it is dropped with one overrun pulse.
        rand_frame(0);
        check("overrun count", 32'(ovr_cnt), 32'(exp_ovr));
        check("held literal", frame_data, 32'h0A0B0000);
        check_frame("held");

        // Consumer accepts in the very cycle a third frame completes.
        rand_frame(S + 2);
        check_frame("frame3");
        check("no extra overrun", 32'(ovr_cnt), 32'(exp_ovr));
        accept("frame3");

        // Fully lit digit 5 and blank digit 3.
        seq(64'hC0_C0_00_C0_FF_C0_C0_C0, 0, 7, 10);
        check_frame("special");
        check("special data", frame_data, 32'h00800000);
        check("special err", 32'(frame_err), 32'h08);
        check("special dp", 32'(frame_dp), 32'h20);
        accept("special");

        // Digit 2 dwell too short to settle, then a full dwell on it.
        seq(64'hF9_A4_B0_99_92_82_F9_C0, 0, 1, 10);
        dwell(8'hFB, 8'h82, 3, 0);
        seq(64'hF9_A4_B0_99_92_82_F9_C0, 3, 7, 10);
        check_frame("short dwell");
        dwell(8'hFB, 8'h80, 10, 0);
        check_frame("after long dwell");
        accept("short");

        // Two strobes low mid-frame: one fault, no sample, captured digits kept.
        seq(64'h8E_86_A1_C6_83_88_98_80, 4, 7, 10);
        dwell(8'hFC, 8'h40, 20, 0);
        check("fault count", 32'(flt_cnt), 32'(exp_flt));
        seq(64'h8E_86_A1_C6_83_88_98_80, 0, 3, 10);
        check_frame("fault frame");
        accept("fault");

        // Reset with a pending frame and five digits captured.
        rand_frame(0);
        seq(64'hC0_C0_C0_86_86_86_86_86, 0, 4, 10);
        rst = 1'b1;
        tick();
        check_idle_outputs("mid reset");
        rst = 1'b0;
        model_reset();
        dwell(8'hEF, 8'hA4, 10, 0);
        seq(64'h80_F8_82_A4_99_B0_A4_F9, 5, 7, 10);
        check_frame("partial after reset");
        seq(64'h80_F8_82_A4_99_B0_A4_F9, 0, 3, 10);
        check_frame("post reset frame");
        accept("post reset");

        for (int r = 0; r < 4; r++) begin
            rand_frame(0);
            check_frame("random");
            accept("random");
        end

        repeat (3) tick();
        check("final overrun", 32'(ovr_cnt), 32'(exp_ovr));
        check("final fault", 32'(flt_cnt), 32'(exp_flt));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
